// File: rtl/inst_rom_responder.sv
// inst_rom_responder
//   Instruction-fetch responder with a one-line buffer. Fetches that hit the
//   buffered line return data combinationally. A miss fills the whole line from
//   a slower backing memory over a req/ack bus, and stalls the CPU until the
//   line is ready.
//
//   Optional feature macro: ROM_STATS_EN (adds saturating hit/miss counters).
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   rom_ce_i     fetch enable
//   rom_addr_i   fetch byte address (bits [1:0] ignored)
//   rom_data_o   instruction word (0 unless hit)
//   stall_req_o  requested word not yet available
//   flush_i      invalidate the line buffer
//   mem_req_o    backing-memory read request (registered)
//   mem_addr_o   word-aligned request address (registered)
//   mem_ack_i    backing memory returns mem_data_i this cycle
//   mem_data_i   backing-memory read data
//   hit_cnt_o    hit cycle counter        (ROM_STATS_EN)
//   miss_cnt_o   line fill counter        (ROM_STATS_EN)
module inst_rom_responder #(
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rom_ce_i,
   input  logic [ADDR_W-1:0] rom_addr_i,
   output logic [DATA_W-1:0] rom_data_o,
   output logic              stall_req_o,
   input  logic              flush_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_data_i
`ifdef ROM_STATS_EN
   ,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
`endif
);

   localparam int unsigned IDX_W = $clog2(LINE_WORDS);
   localparam int unsigned OFF_W = IDX_W + 2;
   localparam int unsigned TAG_W = ADDR_W - OFF_W;

   typedef enum logic [0:0] {StIdle, StFill} state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] line_q [LINE_WORDS];
   logic [TAG_W-1:0]  tag_q;
   logic              valid_q;
   logic              flush_pend_q;
   logic [IDX_W-1:0]  idx_q;
   logic              mem_req_q;
   logic [ADDR_W-1:0] mem_addr_q;

   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  req_idx;
   logic              hit;
   logic              fill_start;
   logic              fill_ack;
   logic              last_ack;
   logic              unused_addr;

   assign req_tag     = rom_addr_i[ADDR_W-1:OFF_W];
   assign req_idx     = rom_addr_i[OFF_W-1:2];
   assign unused_addr = ^rom_addr_i[1:0];

   assign hit        = rom_ce_i & valid_q & (tag_q == req_tag) & (state_q == StIdle);
   assign fill_start = rom_ce_i & ~hit & (state_q == StIdle);
   assign fill_ack   = (state_q == StFill) & mem_ack_i;
   assign last_ack   = fill_ack & (idx_q == IDX_W'(LINE_WORDS - 1));

   // Reset gates the stall directly: the miss logic alone would raise it when ce=1.
   assign rom_data_o  = hit ? line_q[req_idx] : '0;
   assign stall_req_o = rst & rom_ce_i & ~hit;
   assign mem_req_o   = mem_req_q;
   assign mem_addr_o  = mem_addr_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (fill_start) state_d = StFill;
         StFill:  if (last_ack)   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         tag_q        <= '0;
         valid_q      <= 1'b0;
         idx_q        <= '0;
         flush_pend_q <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            StIdle: begin
               if (flush_i) valid_q <= 1'b0;
               if (fill_start) begin
                  tag_q      <= req_tag;
                  valid_q    <= 1'b0;
                  idx_q      <= '0;
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= {req_tag, {OFF_W{1'b0}}};
               end
            end
            StFill: begin
               if (flush_i) flush_pend_q <= 1'b1;
               if (mem_ack_i) begin
                  idx_q <= idx_q + IDX_W'(1);
                  if (last_ack) begin
                     mem_req_q    <= 1'b0;
                     mem_addr_q   <= '0;
                     // A flush arriving with the final ack still kills the line.
                     valid_q      <= ~(flush_pend_q | flush_i);
                     flush_pend_q <= 1'b0;
                  end else begin
                     mem_addr_q <= mem_addr_q + ADDR_W'(4);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Line storage needs no reset: it is only read while valid_q is set.
   always_ff @(posedge clk) begin
      if (fill_ack) line_q[idx_q] <= mem_data_i;
   end

`ifdef ROM_STATS_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (hit && (hit_cnt_q != '1))         hit_cnt_q  <= hit_cnt_q + 32'd1;
         if (fill_start && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
